// File: rtl/rr_mux.sv
// N-channel registered mux with valid/ready on every port.
// The output channel is either picked by sel (mode 0) or by round-robin (mode 1).

module rr_mux_lane #(
  parameter int SELW = 2,
  parameter int IDX  = 0
) (
  input  logic            rst_n,
  input  logic            load_en,
  input  logic            gnt_vld,
  input  logic [SELW-1:0] gnt,
  output logic            ready
);
  assign ready = rst_n && load_en && gnt_vld && (gnt == SELW'(IDX));
endmodule

module rr_mux #(
  parameter  int N_CH = 4,
  parameter  int DW   = 8,
  localparam int SELW = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      in_valid,
  input  logic [N_CH*DW-1:0]   in_data,
  output logic [N_CH-1:0]      in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  logic            load_en;
  logic            gnt_vld;
  logic [SELW-1:0] gnt;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] cand;

  assign load_en = !out_valid || out_ready;

  // Mode 1 scans ptr+1 .. ptr (wrapping), so the last winner has lowest priority.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    cand    = '0;
    if (!mode) begin
      if (int'(sel) < N_CH && in_valid[sel]) begin
        gnt_vld = 1'b1;
        gnt     = sel;
      end
    end else begin
      for (int k = 1; k <= N_CH; k++) begin
        cand = SELW'((int'(ptr) + k) % N_CH);
        if (!gnt_vld && in_valid[cand]) begin
          gnt_vld = 1'b1;
          gnt     = cand;
        end
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    rr_mux_lane #(.SELW(SELW), .IDX(i)) u_lane (
      .rst_n   (rst_n),
      .load_en (load_en),
      .gnt_vld (gnt_vld),
      .gnt     (gnt),
      .ready   (in_ready[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SELW'(N_CH - 1);
    end else if (load_en) begin
      if (gnt_vld) begin
        out_valid <= 1'b1;
        out_data  <= in_data[gnt*DW +: DW];
        out_ch    <= gnt;
        if (mode) ptr <= gnt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rr_mux.md
Name: rr_mux

Overview:
Parametrised N-channel, DW-bit registered multiplexer with a valid/ready handshake on every input and on the output.
- Selection is either fixed by a select input (mode 0) or round-robin over the requesting channels (mode 1).
- One output register stage gives 1-cycle latency and full throughput of one transfer per cycle.
- Sits between multiple producer blocks and a single consumer. It is the clocked, multi-channel generation of the basic 4:1 mux.

Parameters:
N_CH  4  number of input channels, legal range 2..16
DW  8  data width per channel in bits
SELW  $clog2(N_CH)  localparam, width of the select and channel-id fields

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  N_CH  per-channel request; bit i belongs to channel i
in_data  in  N_CH*DW  packed input data; channel i occupies in_data[i*DW +: DW]
in_ready  out  N_CH  per-channel accept; one-hot or zero
mode  in  1  0 = fixed select, 1 = round-robin
sel  in  SELW  channel to pass when mode=0; values >= N_CH select nothing
out_valid  out  1  output register holds valid data
out_data  out  DW  registered data
out_ch  out  SELW  index of the channel that out_data came from
out_ready  in  1  consumer accept

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=N_CH-1 so the first search starts at channel 0. While in reset, in_ready=0.
- Reset released mid-transfer: any held output is lost. No transfer completes in the cycle rst_n is low.
- Load enable: load_en = !out_valid || out_ready. This is combinational.
- Grant in mode 0:
  - g = sel when sel < N_CH and in_valid[sel]=1.
  - Otherwise there is no grant.
- Grant in mode 1:
  - Search channels ptr+1, ptr+2, ..., wrapping modulo N_CH, ending at ptr.
  - g is the first channel found with in_valid=1.
  - No grant if all in_valid are 0.
- in_ready[g] = load_en when a grant exists. All other in_ready bits are 0.
- An input transfer happens on a rising edge when in_valid[g] && in_ready[g]. On that edge:
  - out_data <= in_data[g], out_ch <= g, out_valid <= 1.
  - In mode 1 only, ptr <= g.
- No grant and load_en=1: out_valid <= 0 on the next edge. out_data and out_ch hold their last values.
- Output stall (out_valid=1, out_ready=0):
  - out_data, out_ch and out_valid hold stable.
  - All in_ready are 0.
  - ptr does not change.
- Simultaneous output accept and new grant: the new data loads on the same edge with no bubble, giving back-to-back transfers at 1/cycle.
- Latency: input accepted at edge k appears on out_data after edge k, i.e. one cycle.
- Mode or sel change while stalled: grant is re-evaluated combinationally. The held output is unaffected.
- Mode 0 never modifies ptr. Switching from mode 0 to mode 1 resumes searching from the last round-robin grant.
- Round-robin fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,...,N_CH-1,0,... One channel never wins twice while another is waiting.
- Single requester in mode 1: it is granted every cycle, including when it equals ptr (wrap-around case).
- Channel i's valid dropping while not granted carries no obligation. Producers must hold in_data stable while in_valid is high and in_ready is low.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately, without waiting for a clock; after release, the first mode-1 grant is channel 0.
- Fixed-select sweep: N_CH=4, DW=8, data 00,01,10,11 (hex 0x00,0x01,0x10,0x11), mode=0, out_ready=1, sel stepped 0,1,2,3 every 10 time units -> out_data 0x00,0x01,0x10,0x11 one cycle after each change; out_ch matches sel.
- Invalid select: mode=0, sel=2 with in_valid[2]=0 -> in_ready=0000 and out_valid drops after one edge.
- Round-robin fairness: mode=1, in_valid=1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
- Stall and wrap: mode=1, in_valid=1001, out_ready=0 for 3 cycles after the first grant (ch0) -> out_data held and in_ready=0000; then out_ready=1 -> next grants 3,0,3.
- Single requester: mode=1, in_valid=0100 with ptr=2 -> channel 2 is granted every cycle and out_ch stays 2.
